// File: rtl/output_scheduler.sv
// rtl/output_scheduler.sv - buffers timed frames and presents each for its programmed duration
module output_scheduler #(
    parameter int BITS_W   = 42,
    parameter int ID_W     = 6,
    parameter int DUR_W    = 8,
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       wrValid,
    output logic                       wrReady,
    input  logic [BITS_W-1:0]          wrBits,
    input  logic [ID_W+DUR_W-1:0]      wrIdAndDuration,
    input  logic                       enable,
    input  logic                       flush,
    output logic [BITS_W-1:0]          bitsOut,
    output logic [ID_W+DUR_W-1:0]      idAndDurationOut,
    output logic                       frameValid,
    output logic                       frameDone,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDW = ID_W + DUR_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t state, stateNext;

    logic [BITS_W-1:0] bitsMem  [DEPTH];
    logic [IDW-1:0]    idDurMem [DEPTH];
    logic [AW-1:0]     wrPtr, rdPtr;
    logic [PW-1:0]     prescaler;
    logic [DUR_W-1:0]  remaining;
    logic [DUR_W-1:0]  headDur;

    logic push, pop, tick;
    logic loadFrame, clearFrame, advance, expire;

    assign wrReady = (count != CW'(DEPTH));
    assign push    = wrValid && wrReady && !flush;
    assign pop     = loadFrame;
    assign tick    = (prescaler == PW'(TICK_DIV - 1));
    assign headDur = idDurMem[rdPtr][DUR_W-1:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: if (enable && count != '0) stateNext = PLAY;
                PLAY: if (enable && tick && remaining == DUR_W'(1) && count == '0) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Control strobes for the datapath; flush suppresses every one of them.
    always_comb begin
        loadFrame  = 1'b0;
        clearFrame = 1'b0;
        advance    = 1'b0;
        expire     = 1'b0;
        if (!flush) begin
            case (state)
                IDLE: loadFrame = enable && (count != '0);
                PLAY: begin
                    if (enable) begin
                        advance = 1'b1;
                        if (tick && remaining == DUR_W'(1)) begin
                            expire     = 1'b1;
                            loadFrame  = (count != '0);
                            clearFrame = (count == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            bitsMem[wrPtr]  <= wrBits;
            idDurMem[wrPtr] <= wrIdAndDuration;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr            <= '0;
            rdPtr            <= '0;
            count            <= '0;
            prescaler        <= '0;
            remaining        <= '0;
            bitsOut          <= '0;
            idAndDurationOut <= '0;
            frameValid       <= 1'b0;
            frameDone        <= 1'b0;
        end else if (flush) begin
            wrPtr            <= '0;
            rdPtr            <= '0;
            count            <= '0;
            prescaler        <= '0;
            remaining        <= '0;
            bitsOut          <= '0;
            idAndDurationOut <= '0;
            frameValid       <= 1'b0;
            frameDone        <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            count     <= count + CW'(push) - CW'(pop);
            frameDone <= expire;
            if (loadFrame) begin
                bitsOut          <= bitsMem[rdPtr];
                idAndDurationOut <= idDurMem[rdPtr];
                frameValid       <= 1'b1;
                // A zero duration still shows the frame for one tick.
                remaining        <= (headDur == '0) ? DUR_W'(1) : headDur;
                prescaler        <= '0;
            end else if (clearFrame) begin
                bitsOut          <= '0;
                idAndDurationOut <= '0;
                frameValid       <= 1'b0;
                remaining        <= '0;
                prescaler        <= '0;
            end else if (advance) begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                if (tick) remaining <= remaining - DUR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// tb/tb_output_scheduler.sv - directed vector bench for output_scheduler
module tb_output_scheduler;

    logic        clk = 1'b0;
    logic        resetN;
    logic        wrValid, wrReady, enable, flush, frameValid, frameDone;
    logic [41:0] wrBits, bitsOut;
    logic [13:0] wrIdAndDuration, idAndDurationOut;
    logic [2:0]  count;

    logic        wrValid3, wrReady3, enable3, flush3, frameValid3, frameDone3;
    logic [41:0] wrBits3, bitsOut3;
    logic [13:0] wrIdAndDuration3, idAndDurationOut3;
    logic [2:0]  count3;

    int nCmp  = 0;
    int nFail = 0;

    output_scheduler #(.TICK_DIV(1)) dut (
        .clk(clk), .resetN(resetN), .wrValid(wrValid), .wrReady(wrReady),
        .wrBits(wrBits), .wrIdAndDuration(wrIdAndDuration), .enable(enable),
        .flush(flush), .bitsOut(bitsOut), .idAndDurationOut(idAndDurationOut),
        .frameValid(frameValid), .frameDone(frameDone), .count(count)
    );

    output_scheduler #(.TICK_DIV(3)) dut3 (
        .clk(clk), .resetN(resetN), .wrValid(wrValid3), .wrReady(wrReady3),
        .wrBits(wrBits3), .wrIdAndDuration(wrIdAndDuration3), .enable(enable3),
        .flush(flush3), .bitsOut(bitsOut3), .idAndDurationOut(idAndDurationOut3),
        .frameValid(frameValid3), .frameDone(frameDone3), .count(count3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [13:0] wid;
        logic        en;
        logic        fl;
        logic        eValid;
        logic [13:0] eIdDur;
        logic        eDone;
        logic [2:0]  eCnt;
        logic        eReady;
    } vec_t;

    function automatic vec_t mk(input int wv, input int wid, input int en, input int fl,
                                input int eValid, input int eIdDur, input int eDone,
                                input int eCnt, input int eReady);
        vec_t v;
        v.wv = 1'(wv);         v.wid = 14'(wid);       v.en = 1'(en);
        v.fl = 1'(fl);         v.eValid = 1'(eValid);  v.eIdDur = 14'(eIdDur);
        v.eDone = 1'(eDone);   v.eCnt = 3'(eCnt);      v.eReady = 1'(eReady);
        return v;
    endfunction

    function automatic int idd(input int id, input int d);
        return id * 256 + d;
    endfunction

    function automatic logic [41:0] payload(input logic [5:0] id);
        logic [41:0] p;
        p = (id == 6'd5) ? 42'h2AA_AAAA_AAAA : {30'h1234_5678, 6'd0, id};
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run3(input int idDur, input bit doPause, input int expVis);
        int vis = 0;
        int dn = 0;
        logic [13:0] f;
        f = 14'(idDur);
        for (int c = 0; c < 25; c++) begin
            bit paused;
            paused = doPause && c >= 3 && c <= 7;
            wrValid3 = (c == 0);
            wrIdAndDuration3 = f;
            wrBits3 = payload(f[13:8]);
            enable3 = !paused;
            @(posedge clk); #1;
            if (frameValid3) vis++;
            if (frameDone3) dn++;
            if (paused) begin
                chk($sformatf("pause%0d.idDur", c), 64'(idAndDurationOut3), 64'(f));
                chk($sformatf("pause%0d.bits", c), 64'(bitsOut3), 64'(payload(f[13:8])));
            end
        end
        chk($sformatf("div3.visible.%0d", doPause), 64'(vis), 64'(expVis));
        chk($sformatf("div3.done.%0d", doPause), 64'(dn), 64'd1);
        chk($sformatf("div3.endValid.%0d", doPause), 64'(frameValid3), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        resetN = 1'b0;
        wrValid = 0; wrBits = '0; wrIdAndDuration = '0; enable = 0; flush = 0;
        wrValid3 = 0; wrBits3 = '0; wrIdAndDuration3 = '0; enable3 = 0; flush3 = 0;

        // Sequence A: single frame, duration 3
        vecs.push_back(mk(1, idd(5,3), 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(5,3), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(5,3), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(5,3), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
        // Sequence B: back-to-back durations 2,1,4
        vecs.push_back(mk(1, idd(1,2), 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, idd(2,1), 0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, idd(3,4), 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(1,2), 0, 2, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(1,2), 0, 2, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(2,1), 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(3,4), 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(3,4), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(3,4), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(3,4), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1));
        // Sequence C: overfill with wrValid held
        vecs.push_back(mk(1, idd(10,1), 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, idd(11,1), 0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, idd(12,1), 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(1, idd(13,1), 0, 0, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, idd(14,1), 0, 0, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, idd(14,1), 0, 0, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, idd(14,1), 1, 0, 1, idd(10,1), 0, 3, 1));
        vecs.push_back(mk(1, idd(14,1), 1, 0, 1, idd(11,1), 1, 3, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(12,1), 1, 2, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(13,1), 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, idd(14,1), 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
        // Sequence D: duration 0, then flush with two frames queued
        vecs.push_back(mk(1, idd(20,0), 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, idd(21,5), 1, 0, 1, idd(20,0), 0, 1, 1));
        vecs.push_back(mk(1, idd(22,5), 1, 0, 1, idd(21,5), 1, 1, 1));
        vecs.push_back(mk(1, idd(23,5), 1, 0, 1, idd(21,5), 0, 2, 1));
        vecs.push_back(mk(1, idd(24,5), 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("rst.bits", 64'(bitsOut), 64'd0);
        chk("rst.idDur", 64'(idAndDurationOut), 64'd0);
        chk("rst.valid", 64'(frameValid), 64'd0);
        chk("rst.done", 64'(frameDone), 64'd0);
        chk("rst.ready", 64'(wrReady), 64'd1);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst3.ready", 64'(wrReady3), 64'd1);
        chk("rst3.count", 64'(count3), 64'd0);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [41:0] eBits;
            wrValid = vecs[i].wv;
            wrIdAndDuration = vecs[i].wid;
            wrBits = payload(vecs[i].wid[13:8]);
            enable = vecs[i].en;
            flush = vecs[i].fl;
            eBits = vecs[i].eValid ? payload(vecs[i].eIdDur[13:8]) : 42'd0;
            @(posedge clk); #1;
            chk($sformatf("v%0d.valid", i), 64'(frameValid), 64'(vecs[i].eValid));
            chk($sformatf("v%0d.idDur", i), 64'(idAndDurationOut), 64'(vecs[i].eIdDur));
            chk($sformatf("v%0d.bits", i), 64'(bitsOut), 64'(eBits));
            chk($sformatf("v%0d.done", i), 64'(frameDone), 64'(vecs[i].eDone));
            chk($sformatf("v%0d.count", i), 64'(count), 64'(vecs[i].eCnt));
            chk($sformatf("v%0d.ready", i), 64'(wrReady), 64'(vecs[i].eReady));
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a frame with one queued behind it
        enable = 1'b1;
        wrValid = 1'b1; wrIdAndDuration = 14'(idd(30,9)); wrBits = payload(6'd30);
        @(posedge clk); #1;
        wrIdAndDuration = 14'(idd(31,9)); wrBits = payload(6'd31);
        @(posedge clk); #1;
        wrValid = 1'b0;
        @(posedge clk); #1;
        chk("arst.pre.valid", 64'(frameValid), 64'd1);
        chk("arst.pre.count", 64'(count), 64'd1);
        #2 resetN = 1'b0;
        #1;
        chk("arst.valid", 64'(frameValid), 64'd0);
        chk("arst.bits", 64'(bitsOut), 64'd0);
        chk("arst.idDur", 64'(idAndDurationOut), 64'd0);
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.ready", 64'(wrReady), 64'd1);
        @(posedge clk); #1;
        chk("arst.done", 64'(frameDone), 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        enable = 1'b0;

        run3(idd(7,2), 1'b0, 6);
        run3(idd(8,2), 1'b1, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
